// File: rtl/vend_controller.sv
// Coin-queue front end for a vending FSM: buffers coin tokens, feeds them one
// at a time as pulses, then sequences the dispense and change-payout handshakes.
module vend_controller #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_valid,
  input  logic [1:0] coin_type,
  output logic       coin_ready,
  output logic       one,
  output logic       two,
  output logic       five,
  input  logic       d_in,
  input  logic [2:0] r_in,
  output logic       disp_req,
  input  logic       disp_ack,
  output logic       chg_valid,
  output logic       chg_two,
  input  logic       chg_ready,
  output logic [7:0] vend_count
);

  typedef enum logic [2:0] {IDLE, FEED, CHECK, DISPENSE, CHANGE} state_t;

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  state_t        state;
  logic [1:0]    coin_reg;
  logic [2:0]    chg_reg;
  logic          full, empty, push, pop;
  logic [1:0]    head;
  logic [2:0]    chg_next;

  assign full       = (count == (AW+1)'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign coin_ready = !full;
  assign push       = coin_valid && !full;
  assign pop        = (state == IDLE) && !empty;
  assign head       = mem[rd_ptr];
  assign chg_next   = chg_reg - ((chg_reg >= 3'd2) ? 3'd2 : 3'd1);

  // NOTE: the storage array is deliberately left out of reset; occupancy is
  // tracked by count, so stale entries are never read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= coin_type;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      coin_reg   <= '0;
      chg_reg    <= '0;
      vend_count <= '0;
      one        <= 1'b0;
      two        <= 1'b0;
      five       <= 1'b0;
      disp_req   <= 1'b0;
      chg_valid  <= 1'b0;
      chg_two    <= 1'b0;
    end else begin
      // NOTE: pulses default low every cycle so each one lasts exactly the FEED cycle.
      one  <= 1'b0;
      two  <= 1'b0;
      five <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            coin_reg <= head;
            one      <= (head == 2'b01);
            two      <= (head == 2'b10);
            five     <= (head == 2'b11);
            state    <= FEED;
          end
        end
        FEED: begin
          if (coin_reg == 2'b00) begin
            state <= IDLE;
          end else begin
            chg_reg <= r_in;
            state   <= CHECK;
          end
        end
        CHECK: begin
          if (d_in) begin
            disp_req <= 1'b1;
            state    <= DISPENSE;
          end else begin
            chg_reg <= '0;
            state   <= IDLE;
          end
        end
        DISPENSE: begin
          if (disp_ack) begin
            disp_req   <= 1'b0;
            vend_count <= vend_count + 8'd1;
            if (chg_reg != 3'd0) begin
              chg_valid <= 1'b1;
              chg_two   <= (chg_reg >= 3'd2);
              state     <= CHANGE;
            end else begin
              state <= IDLE;
            end
          end
        end
        CHANGE: begin
          if (chg_ready) begin
            chg_reg <= chg_next;
            if (chg_next == 3'd0) begin
              chg_valid <= 1'b0;
              chg_two   <= 1'b0;
              state     <= IDLE;
            end else begin
              chg_two <= (chg_next >= 3'd2);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: plays the vending FSM (price 5 cents) and the
// dispenser/change devices, and compares logged activity with a credit model.
module tb_vend_controller;

  logic       clk, reset;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       coin_ready;
  logic       one, two, five;
  logic       d_in;
  logic [2:0] r_in;
  logic       disp_req, disp_ack;
  logic       chg_valid, chg_two, chg_ready;
  logic [7:0] vend_count;

  int checks = 0;
  int errors = 0;

  int  credit;
  bit  ack_hold, ready_hold, noise;
  int  ack_pct, rdy_pct;

  logic [1:0] sent_q[$];
  int         pulse_q[$];
  int         tok_q[$];

  vend_controller #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_type(coin_type),
    .coin_ready(coin_ready), .one(one), .two(two), .five(five), .d_in(d_in),
    .r_in(r_in), .disp_req(disp_req), .disp_ack(disp_ack), .chg_valid(chg_valid),
    .chg_two(chg_two), .chg_ready(chg_ready), .vend_count(vend_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int coin_value(input logic [1:0] t);
    case (t)
      2'b01:   return 1;
      2'b10:   return 2;
      2'b11:   return 5;
      default: return 0;
    endcase
  endfunction

  // Vending FSM stand-in: change is combinational in the pulse cycle, dispense is registered.
  always_comb begin
    int pv;
    pv   = one ? 1 : (two ? 2 : (five ? 5 : 0));
    r_in = (credit + pv >= 5) ? 3'(credit + pv - 5) : 3'd0;
  end

  initial begin
    int pv;
    bit hit;
    forever begin
      @(negedge clk);
      pv  = one ? 1 : (two ? 2 : (five ? 5 : 0));
      hit = (pv != 0) && (credit + pv >= 5);
      @(posedge clk); #1;
      if (reset) begin
        credit = 0;
        d_in   = 1'b0;
      end else begin
        d_in = hit;
        if (pv != 0) credit = hit ? 0 : credit + pv;
      end
    end
  end

  // Dispenser and change devices; with noise, acks also appear when nothing is requested.
  initial begin
    forever begin
      @(posedge clk); #1;
      disp_ack  = disp_req  ? (!ack_hold   && ($urandom_range(0, 99) < ack_pct))
                            : (noise && ($urandom_range(0, 7) == 0));
      chg_ready = chg_valid ? (!ready_hold && ($urandom_range(0, 99) < rdy_pct))
                            : (noise && ($urandom_range(0, 7) == 0));
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (one || two || five) begin
          check("pulse_onehot", int'(one) + int'(two) + int'(five), 1);
          pulse_q.push_back(one ? 1 : (two ? 2 : 5));
        end
        if (chg_valid && chg_ready) tok_q.push_back(int'(chg_two));
      end
    end
  end

  // Called just after a rising edge; returns just after a rising edge.
  task automatic apply_reset(input string tag);
    reset      = 1'b1;
    coin_valid = 1'b0;
    ack_hold   = 1'b0;
    ready_hold = 1'b0;
    credit     = 0;
    d_in       = 1'b0;
    #1;
    check({tag, "_coin_ready"}, coin_ready, 1);
    check({tag, "_vend_count"}, vend_count, 0);
    check({tag, "_chg_valid"},  chg_valid, 0);
    check({tag, "_disp_req"},   disp_req, 0);
    check({tag, "_pulses"},     {one, two, five}, 0);
    sent_q.delete();
    pulse_q.delete();
    tok_q.delete();
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
  endtask

  task automatic offer(input logic [1:0] t);
    int w;
    coin_valid = 1'b1;
    coin_type  = t;
    w = 0;
    @(negedge clk);
    while (!coin_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("coin_accept_in_time", (w < 200), 1);
    sent_q.push_back(t);
    @(posedge clk); #1;
    coin_valid = 1'b0;
  endtask

  task automatic wait_quiet(input string tag);
    int idle, t;
    idle = 0;
    t    = 0;
    while (idle < 12 && t < 3000) begin
      @(negedge clk);
      t++;
      if (one || two || five || disp_req || chg_valid || coin_valid) idle = 0;
      else idle++;
    end
    check({tag, "_quiesced"}, (idle >= 12), 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_high(input string tag, input int which);
    int w;
    w = 0;
    @(negedge clk);
    while (((which == 0) ? !disp_req : !chg_valid) && w < 300) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_reached"}, (w < 300), 1);
  endtask

  // Expected pulses, change tokens and vends, from credit arithmetic on accepted coins.
  task automatic compare_run(input string tag);
    int cr, ch, v, vends;
    int ep[$];
    int et[$];
    cr    = 0;
    vends = 0;
    foreach (sent_q[i]) begin
      v = coin_value(sent_q[i]);
      if (v == 0) continue;
      ep.push_back(v);
      cr += v;
      if (cr >= 5) begin
        vends++;
        ch = cr - 5;
        cr = 0;
        while (ch > 0) begin
          if (ch >= 2) begin et.push_back(1); ch -= 2; end
          else begin et.push_back(0); ch -= 1; end
        end
      end
    end
    check({tag, "_vend_count"}, vend_count, vends % 256);
    check({tag, "_num_pulses"}, pulse_q.size(), ep.size());
    foreach (ep[i])
      if (i < pulse_q.size()) check($sformatf("%s_pulse%0d", tag, i), pulse_q[i], ep[i]);
    check({tag, "_num_tokens"}, tok_q.size(), et.size());
    foreach (et[i])
      if (i < tok_q.size()) check($sformatf("%s_token%0d", tag, i), tok_q[i], et[i]);
  endtask

  initial begin
    int w;
    reset = 1'b1; coin_valid = 1'b0; coin_type = 2'b00; d_in = 1'b0;
    disp_ack = 1'b0; chg_ready = 1'b0; credit = 0;
    noise = 1'b0; ack_pct = 100; rdy_pct = 100;
    @(posedge clk); #1;

    // Single 5-cent coin with the dispense ack stalled.
    apply_reset("rst0");
    ack_hold = 1'b1;
    offer(2'b11);
    @(negedge clk);
    @(negedge clk);
    check("five_pulse", {one, two, five}, 3'b001);
    @(negedge clk);
    check("five_one_cycle", five, 0);
    check("no_req_in_check", disp_req, 0);
    @(negedge clk);
    check("req_after_check", disp_req, 1);
    repeat (3) begin
      @(negedge clk);
      check("req_held_no_ack", disp_req, 1);
      check("vend_count_waits", vend_count, 0);
    end
    ack_hold = 1'b0;
    @(posedge clk); #1;
    wait_quiet("single5");
    check("single5_count", vend_count, 1);
    compare_run("single5");

    // 2, 2, 5: change of 4 paid as two 2-cent tokens.
    apply_reset("rst1");
    offer(2'b10); offer(2'b10); offer(2'b11);
    wait_quiet("c225");
    compare_run("c225");

    // 1, 5: one 1-cent token, chg_ready withheld for 3 cycles.
    apply_reset("rst2");
    ready_hold = 1'b1;
    offer(2'b01); offer(2'b11);
    wait_high("c15_chg", 1);
    repeat (3) begin
      @(negedge clk);
      check("chg_valid_stable", chg_valid, 1);
      check("chg_two_stable", chg_two, 0);
    end
    ready_hold = 1'b0;
    @(posedge clk); #1;
    wait_quiet("c15");
    compare_run("c15");

    // Queue fills while the dispenser stalls; fifth coin held off until a pop.
    apply_reset("rst3");
    ack_hold = 1'b1;
    offer(2'b11);
    wait_high("fill_disp", 0);
    @(posedge clk); #1;
    coin_valid = 1'b1;
    coin_type  = 2'b01;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("fill_ready%0d", i), coin_ready, 1);
      sent_q.push_back(2'b01);
      @(posedge clk); #1;
    end
    repeat (3) begin
      @(negedge clk);
      check("full_holdoff", coin_ready, 0);
      @(posedge clk); #1;
    end
    ack_hold = 1'b0;
    w = 0;
    @(negedge clk);
    while (!coin_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("slot_freed", (w < 100), 1);
    sent_q.push_back(2'b01);
    @(posedge clk); #1;
    coin_valid = 1'b0;
    wait_quiet("fill");
    compare_run("fill");

    // Five 1-cent coins, preceded by an illegal token that must be discarded.
    apply_reset("rst4");
    offer(2'b00);
    for (int i = 0; i < 5; i++) offer(2'b01);
    wait_quiet("ones");
    compare_run("ones");

    // Reset during CHANGE with two coins queued.
    apply_reset("rst5");
    ready_hold = 1'b1;
    offer(2'b10); offer(2'b10); offer(2'b11);
    wait_high("midrst_chg", 1);
    @(posedge clk); #1;
    offer(2'b01); offer(2'b10);
    check("midrst_in_change", chg_valid, 1);
    apply_reset("midrst");
    wait_quiet("midrst");
    check("midrst_queue_flushed", pulse_q.size(), 0);
    check("midrst_no_tokens", tok_q.size(), 0);
    check("midrst_vend_count", vend_count, 0);

    // Randomized rounds with random handshake latency and spurious acks.
    for (int r = 0; r < 3; r++) begin
      apply_reset($sformatf("rst_rand%0d", r));
      noise   = 1'b1;
      ack_pct = $urandom_range(20, 90);
      rdy_pct = $urandom_range(20, 90);
      for (int i = 0; i < 40; i++) begin
        offer(2'($urandom_range(0, 3)));
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
      wait_quiet($sformatf("rand%0d", r));
      compare_run($sformatf("rand%0d", r));
      noise = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
